// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage sitting in front of ID decode.
// It owns the PC, fetches one instruction at a time from the instruction
// SRAM over a req/addr_ok/data_ok handshake, and holds each returned word
// for ID until the pipeline lets the PC advance. Branches from ID take
// effect after the delay-slot instruction (MIPS semantics): the fetch that
// is already in flight is always delivered, and the branch target becomes
// the PC on the next advance.
//
// Ports
//   clk            in   1   clock, all state updates on posedge
//   rst_n          in   1   asynchronous reset, active-low
//   stall          in   6   pipeline stall bus; stall[0]=1 holds the PC stage
//   br_bus         in  33   {br_e, br_addr[31:0]} from ID
//   inst_req       out  1   SRAM request valid
//   inst_addr      out 32   SRAM request address
//   inst_addr_ok   in   1   SRAM accepted the request
//   inst_data_ok   in   1   inst_rdata is valid
//   inst_rdata     in  32   returned instruction word
//   if_to_id_bus   out 33   {ce, pc[31:0]} to ID
//   inst_o         out 32   instruction matching if_to_id_bus pc
//   stallreq       out  1   fetch not ready, asks CTRL to stall
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [32:0] if_to_id_bus,
    output logic [31:0] inst_o,
    output logic        stallreq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic NO_STOP = 1'b0;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        redir_v_q, redir_v_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic [31:0] pc_buf_q, pc_buf_d;

    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] next_pc;
    logic        advance;

    // Only stall[0] concerns this stage; the other bits belong to later stages.
    logic        unused_stall;
    assign unused_stall = ^stall[5:1];

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];

    // A branch seen in the advancing cycle wins over one remembered earlier,
    // which in turn wins over the sequential PC (32-bit wraparound intended).
    assign next_pc = br_e      ? br_addr    :
                     redir_v_q ? redir_pc_q :
                                 pc_q + 32'd4;

    // State, PC, redirect and instruction buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            redir_v_q  <= 1'b0;
            redir_pc_q <= 32'b0;
            inst_buf_q <= 32'b0;
            pc_buf_q   <= 32'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_v_q  <= redir_v_d;
            redir_pc_q <= redir_pc_d;
            inst_buf_q <= inst_buf_d;
            pc_buf_q   <= pc_buf_d;
        end
    end

    // Next-state and output logic. Outputs depend on state only, so ID and
    // the SRAM never see a combinational path from their own inputs.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_v_d    = redir_v_q;
        redir_pc_d   = redir_pc_q;
        inst_buf_d   = inst_buf_q;
        pc_buf_d     = pc_buf_q;
        advance      = 1'b0;
        inst_req     = 1'b0;
        inst_addr    = pc_q;
        if_to_id_bus = 33'b0;
        inst_o       = 32'b0;
        stallreq     = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                inst_req = 1'b1;
                stallreq = 1'b1;
                // A data_ok arriving together with addr_ok belongs to no
                // request of ours yet, so only addr_ok is looked at here.
                if (inst_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stallreq = 1'b1;
                if (inst_data_ok) begin
                    inst_buf_d = inst_rdata;
                    pc_buf_d   = pc_q;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if_to_id_bus = {1'b1, pc_buf_q};
                inst_o       = inst_buf_q;
                if (stall[0] == NO_STOP) begin
                    advance = 1'b1;
                    pc_d    = next_pc;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A branch target is remembered until the advance that consumes it.
        // When the branch coincides with the advance it is used directly,
        // so nothing is left pending.
        if (br_e) begin
            redir_pc_d = br_addr;
        end
        if (advance) begin
            redir_v_d = 1'b0;
        end else if (br_e) begin
            redir_v_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Self-checking bench for if_fetch_unit. A transaction-level model tracks
// which fetch is in progress, its PC, the pending branch target and the
// delivered instruction; a compare process checks every DUT output against
// it on every falling edge. Directed sequences pin the model with literal
// expectations, then randomized SRAM handshakes, stalls, branches and
// reset pulses exercise the rest.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_WAIT = 2;
    localparam int P_HOLD = 3;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [32:0] if_to_id_bus;
    logic [31:0] inst_o;
    logic        stallreq;

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    // Model state: phase of the current fetch, its PC, the delivered word
    // and an optional pending branch target.
    int          mPhase;
    logic [31:0] mPc;
    logic [31:0] mBuf;
    logic [31:0] mBufPc;
    logic [31:0] pend[$];

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clock),
        .rst_n        (rst_n),
        .stall        (stall),
        .br_bus       (br_bus),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_to_id_bus (if_to_id_bus),
        .inst_o       (inst_o),
        .stallreq     (stallreq)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = P_IDLE;
        mPc    = RESET_PC;
        mBuf   = 32'b0;
        mBufPc = 32'b0;
        pend.delete();
    endtask

    // One clock of the fetch rules, applied to the inputs present at the edge.
    task automatic modelStep();
        bit          adv;
        logic [31:0] target;
        adv = 1'b0;
        case (mPhase)
            P_IDLE: mPhase = P_REQ;
            P_REQ:  if (inst_addr_ok) mPhase = P_WAIT;
            P_WAIT: if (inst_data_ok) begin
                mBuf   = inst_rdata;
                mBufPc = mPc;
                mPhase = P_HOLD;
            end
            default: if (!stall[0]) begin
                adv = 1'b1;
                if (br_bus[32])          target = br_bus[31:0];
                else if (pend.size() > 0) target = pend[0];
                else                      target = mPc + 32'd4;
                mPc = target;
                pend.delete();
                mPhase = P_REQ;
            end
        endcase
        if (br_bus[32] && !adv) begin
            pend.delete();
            pend.push_back(br_bus[31:0]);
        end
    endtask

    // Inputs change 2 time units after the falling edge, well clear of both
    // clock edges; the model follows each rising edge while out of reset.
    task automatic applyStimulus(input bit aOk, input bit dOk, input logic [31:0] rd,
                                 input bit stl, input bit bE, input logic [31:0] bA);
        #2;
        inst_addr_ok = aOk;
        inst_data_ok = dOk;
        inst_rdata   = rd;
        stall        = {5'($urandom), stl};
        br_bus       = {bE, bA};
        @(posedge clock);
        if (rst_n) modelStep();
        @(negedge clock);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // From REQ: accept the request, then return rd; ends in HOLD.
    task automatic fetchOne(input logic [31:0] rd);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, rd, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic assertReset();
        #2;
        rst_n = 1'b0;
        modelReset();
    endtask

    task automatic releaseReset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_inst_req"}, inst_req, 1'b0);
        checkOutput({tag, "_inst_addr"}, inst_addr, RESET_PC);
        checkOutput({tag, "_bus"}, if_to_id_bus, 33'b0);
        checkOutput({tag, "_inst_o"}, inst_o, 32'b0);
        checkOutput({tag, "_stallreq"}, stallreq, 1'b0);
    endtask

    // Every falling edge: all outputs against the model.
    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("model_inst_req", inst_req, (mPhase == P_REQ));
            checkOutput("model_inst_addr", inst_addr, mPc);
            checkOutput("model_bus", if_to_id_bus, (mPhase == P_HOLD) ? {1'b1, mBufPc} : 33'b0);
            checkOutput("model_inst_o", inst_o, (mPhase == P_HOLD) ? mBuf : 32'b0);
            checkOutput("model_stallreq", stallreq, (mPhase == P_REQ) || (mPhase == P_WAIT));
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        rst_n        = 1'b0;
        stall        = 6'b0;
        br_bus       = 33'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'b0;
        modelReset();
        checkEn = 1'b1;
        repeat (2) @(negedge clock);
        checkResetOutputs("reset");

        // First fetch at the reset vector with a zero-wait SRAM.
        releaseReset();
        idleCycle();
        checkOutput("t1_req", inst_req, 1'b1);
        checkOutput("t1_addr", inst_addr, 32'hBFC0_0000);
        checkOutput("t1_stallreq", stallreq, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t1_wait_req", inst_req, 1'b0);
        checkOutput("t1_wait_stallreq", stallreq, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h3C01_1234, 1'b0, 1'b0, 32'h0);
        checkOutput("t1_hold_bus", if_to_id_bus, {1'b1, 32'hBFC0_0000});
        checkOutput("t1_hold_inst", inst_o, 32'h3C01_1234);
        checkOutput("t1_hold_stallreq", stallreq, 1'b0);
        idleCycle();
        checkOutput("t1_next_addr", inst_addr, 32'hBFC0_0004);

        // Request held while the SRAM withholds addr_ok.
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            checkOutput("t2_req", inst_req, 1'b1);
            checkOutput("t2_addr", inst_addr, 32'hBFC0_0004);
            checkOutput("t2_stallreq", stallreq, 1'b1);
            checkOutput("t2_ce", if_to_id_bus[32], 1'b0);
        end
        fetchOne(32'h2402_0005);

        // Stall while holding: everything frozen.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            checkOutput("t3_bus", if_to_id_bus, {1'b1, 32'hBFC0_0004});
            checkOutput("t3_inst", inst_o, 32'h2402_0005);
            checkOutput("t3_req", inst_req, 1'b0);
        end
        idleCycle();
        checkOutput("t3_release_addr", inst_addr, 32'hBFC0_0008);

        // Branch during WAIT: delay slot still delivered, target fetched next.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h8C43_0000, 1'b0, 1'b1, 32'hBFC0_0100);
        checkOutput("t4_slot_bus", if_to_id_bus, {1'b1, 32'hBFC0_0008});
        checkOutput("t4_slot_inst", inst_o, 32'h8C43_0000);
        idleCycle();
        checkOutput("t4_target_addr", inst_addr, 32'hBFC0_0100);

        // Branch in the advancing cycle is used directly and leaves nothing pending.
        fetchOne(32'h0000_0000);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBFC0_0200);
        checkOutput("t5_addr", inst_addr, 32'hBFC0_0200);
        fetchOne(32'h0000_0001);
        idleCycle();
        checkOutput("t5_seq_addr", inst_addr, 32'hBFC0_0204);

        // PC wraps modulo 2^32.
        fetchOne(32'h0000_0002);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        checkOutput("wrap_top_addr", inst_addr, 32'hFFFF_FFFC);
        fetchOne(32'h0000_0003);
        idleCycle();
        checkOutput("wrap_zero_addr", inst_addr, 32'h0000_0000);

        // Reset mid-transaction, then a stray data_ok in IDLE.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        assertReset();
        #1;
        checkResetOutputs("t6_async");
        idleCycle();
        releaseReset();
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        checkOutput("t6_req", inst_req, 1'b1);
        checkOutput("t6_addr", inst_addr, 32'hBFC0_0000);
        checkOutput("t6_bus", if_to_id_bus, 33'b0);
        fetchOne(32'h1111_1111);
        checkOutput("t6_hold_bus", if_to_id_bus, {1'b1, 32'hBFC0_0000});
        checkOutput("t6_hold_inst", inst_o, 32'h1111_1111);

        // Randomized handshakes, stalls, branches and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                assertReset();
                idleCycle();
                releaseReset();
            end else begin
                applyStimulus($urandom_range(0, 2) == 0,
                              $urandom_range(0, 2) == 0,
                              $urandom,
                              $urandom_range(0, 3) == 0,
                              $urandom_range(0, 7) == 0,
                              ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC));
            end
        end

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
